// File: rtl/mac9_result_collector.sv
// Samples the free-running MAC-9 result once per window, applies bias, rounding shift,
// ReLU and u8 saturation, and queues the result on a valid/ready stream. Optional: MAC9_COLLECT_STATS_EN.
module mac9_result_collector #(
    parameter int PERIOD       = 9,
    parameter int FIRST_SAMPLE = 10,
    parameter int SKIP_FIRST   = 1,
    parameter int SHIFT        = 2,
    parameter int DEPTH        = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic signed [11:0] mac_out,
    input  logic signed [11:0] bias,
    input  logic              restart,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef MAC9_COLLECT_STATS_EN
    output logic [15:0]       drop_cnt,
    output logic [15:0]       sample_cnt,
`endif
    output logic              overflow
);

    localparam int PH_MAX = (FIRST_SAMPLE > PERIOD) ? FIRST_SAMPLE : PERIOD;
    localparam int PW     = $clog2(PH_MAX + 1);
    localparam int SW     = (SKIP_FIRST > 0) ? $clog2(SKIP_FIRST + 1) : 1;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RND_I  = (2 ** SHIFT) / 2;

    localparam logic [PW-1:0]       PH_FIRST   = PW'(FIRST_SAMPLE);
    localparam logic [PW-1:0]       PH_RESTART = PW'(FIRST_SAMPLE - 1);
    localparam logic [PW-1:0]       PH_PERIOD  = PW'(PERIOD - 1);
    localparam logic [SW-1:0]       SKIP_INIT  = SW'(SKIP_FIRST);
    localparam logic signed [14:0]  RND        = 15'(RND_I);
    localparam logic [AW:0]         FULL_CNT   = (AW + 1)'(DEPTH);

    logic [PW-1:0]       phase_q, phase_d;
    logic [SW-1:0]       skip_q, skip_d;
    logic                samp, take;
    logic signed [13:0]  sum_q, sum_d;
    logic                s1_v_q;
    logic [7:0]          res_q, res_d;
    logic                res_v_q;
    logic signed [14:0]  biased, shifted;

    logic [7:0]          mem_q [DEPTH];
    logic [AW-1:0]       wptr_q, rptr_q;
    logic [AW:0]         count_q, count_d;
    logic                full, pop, wr_en, drop;
    logic                overflow_q;

    // The restart edge itself counts as cycle 0 of the new schedule, so the
    // first strobe after it lands FIRST_SAMPLE cycles later, as after reset.
    always_comb begin
        samp    = (phase_q == '0) && !restart;
        take    = 1'b0;
        skip_d  = skip_q;
        if (restart)
            phase_d = PH_RESTART;
        else if (phase_q == '0)
            phase_d = PH_PERIOD;
        else
            phase_d = phase_q - PW'(1);
        if (restart)
            skip_d = SKIP_INIT;
        else if (samp) begin
            if (skip_q != '0)
                skip_d = skip_q - SW'(1);
            else
                take = 1'b1;
        end
    end

    always_comb begin
        sum_d   = take ? ({{2{mac_out[11]}}, mac_out} + {{2{bias[11]}}, bias}) : sum_q;
        biased  = $signed({sum_q[13], sum_q}) + RND;
        shifted = biased >>> SHIFT;
        if (shifted[14])
            res_d = 8'd0;
        else if (|shifted[13:8])
            res_d = 8'd255;
        else
            res_d = shifted[7:0];
    end

    always_comb begin
        full      = (count_q == FULL_CNT);
        out_valid = (count_q != '0);
        pop       = out_valid && out_ready;
        wr_en     = res_v_q && (!full || pop);
        drop      = res_v_q && full && !pop;
        count_d   = count_q;
        if (wr_en && !pop)
            count_d = count_q + (AW + 1)'(1);
        else if (!wr_en && pop)
            count_d = count_q - (AW + 1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= PH_FIRST;
            skip_q     <= SKIP_INIT;
            sum_q      <= '0;
            s1_v_q     <= 1'b0;
            res_q      <= '0;
            res_v_q    <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            phase_q <= phase_d;
            skip_q  <= skip_d;
            sum_q   <= sum_d;
            s1_v_q  <= take;
            res_q   <= res_d;
            res_v_q <= s1_v_q;
            count_q <= count_d;
            if (wr_en) begin
                mem_q[wptr_q] <= res_q;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (pop)
                rptr_q <= rptr_q + AW'(1);
            if (drop)
                overflow_q <= 1'b1;
        end
    end

    assign out_data = mem_q[rptr_q];
    assign overflow = overflow_q;

`ifdef MAC9_COLLECT_STATS_EN
    logic [15:0] drop_cnt_q, sample_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q   <= '0;
            sample_cnt_q <= '0;
        end else begin
            if (drop && drop_cnt_q != '1)
                drop_cnt_q <= drop_cnt_q + 16'd1;
            if (wr_en && sample_cnt_q != '1)
                sample_cnt_q <= sample_cnt_q + 16'd1;
        end
    end

    assign drop_cnt   = drop_cnt_q;
    assign sample_cnt = sample_cnt_q;
`endif

endmodule
